// File: rtl/alu_issue_if.sv
// alu_issue_if: operand-beat input stream and result output stream of the issue controller
interface alu_issue_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_v;
    logic             res_c;
    logic             res_valid;
    logic             res_ready;
    modport master (
        output in_data, in_op, in_valid, res_ready,
        input  in_ready, res_data, res_v, res_c, res_valid
    );
    modport slave (
        input  in_data, in_op, in_valid, res_ready,
        output in_ready, res_data, res_v, res_c, res_valid
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: collects A/B operand beats, drives an external ALU, captures and holds its result
module alu_issue_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_if.slave       bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_v,
    input  logic             alu_c,
    output logic [7:0]       op_count
);
    typedef enum logic [1:0] {IDLE, GOT_A, EXEC, RESULT} state_t;
    state_t state, state_nx;
    logic load_a, load_b, capture, done;
    assign bus.in_ready = (state == IDLE) || (state == GOT_A);
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next state and datapath strobes; EXEC always lasts a single cycle
    always_comb begin
        state_nx = state;
        load_a   = 1'b0;
        load_b   = 1'b0;
        capture  = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (bus.in_valid) begin
                load_a   = 1'b1;
                state_nx = GOT_A;
            end
            GOT_A: if (bus.in_valid) begin
                load_b   = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                capture  = 1'b1;
                state_nx = RESULT;
            end
            RESULT: if (bus.res_ready) begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    // operand, result and counter registers; flags are taken verbatim from the ALU
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_sel       <= 2'b00;
            bus.res_data  <= '0;
            bus.res_v     <= 1'b0;
            bus.res_c     <= 1'b0;
            bus.res_valid <= 1'b0;
            op_count      <= 8'd0;
        end else begin
            if (load_a) alu_a <= bus.in_data;
            if (load_b) begin
                alu_b   <= bus.in_data;
                alu_sel <= bus.in_op;
            end
            if (capture) begin
                bus.res_data  <= alu_out;
                bus.res_v     <= alu_v;
                bus.res_c     <= alu_c;
                bus.res_valid <= 1'b1;
            end else if (done) begin
                bus.res_valid <= 1'b0;
            end
            if (done) op_count <= op_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl driving a behavioural ALU
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alu_a, alu_b, alu_out, op_count;
    logic [1:0] alu_sel;
    logic       alu_v, alu_c;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [9:0] exp_q[$];

    alu_issue_if #(.WIDTH(8)) bus ();

    alu_issue_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_v(alu_v), .alu_c(alu_c),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // ALU: 00 add, 01 sub (C = borrow), 10 increment A, 11 pass A; returns {V, C, OUT}
    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [8:0] s;
        logic v;
        case (op)
            2'b00: begin s = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (s[7] != a[7]); end
            2'b01: begin s = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (s[7] != a[7]); end
            2'b10: begin s = {1'b0, a} + 9'd1;      v = (a == 8'h7F); end
            default: begin s = {1'b0, a};           v = 1'b0; end
        endcase
        return {v, s[8], s[7:0]};
    endfunction

    always_comb {alu_v, alu_c, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

    task automatic send_beat(input logic [7:0] d, input logic [1:0] op);
        int n = 0;
        bus.in_data  = d;
        bus.in_op    = op;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n == 20) begin
            errors++;
            $display("FAIL beat_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input int stall, input logic [9:0] exp);
        logic [9:0] e;
        bus.res_ready = (stall == 0);
        exp_q.push_back(exp);
        send_beat(a, 2'b00);
        send_beat(b, op);
        checks++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL exec_cycle: res_valid=%b in_ready=%b required 0 0", bus.res_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: res_valid=%b required 1 two edges after B", bus.res_valid);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
        checks++;
        if ({bus.res_v, bus.res_c, bus.res_data} !== e) begin
            errors++;
            $display("FAIL result: v/c/data=%b/%b/%h required %b/%b/%h",
                     bus.res_v, bus.res_c, bus.res_data, e[9], e[8], e[7:0]);
        end
        checks++;
        if ({alu_a, alu_b, alu_sel} !== {a, b, op}) begin
            errors++;
            $display("FAIL operands: a=%h b=%h sel=%b required %h %h %b", alu_a, alu_b, alu_sel, a, b, op);
        end
        if (stall > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hAA;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                checks++;
                if (bus.res_valid !== 1'b1 || {bus.res_v, bus.res_c, bus.res_data} !== e ||
                    bus.in_ready !== 1'b0 || alu_a !== a) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h ready=%b alu_a=%h required 1 %h 0 %h",
                             bus.res_valid, bus.res_data, bus.in_ready, alu_a, e[7:0], a);
                end
            end
            bus.res_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_cnt++;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0 || op_count !== exp_cnt) begin
            errors++;
            $display("FAIL release: in_ready=%b res_valid=%b op_count=%0d required 1 0 %0d",
                     bus.in_ready, bus.res_valid, op_count, exp_cnt);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({alu_a, alu_b, alu_sel, bus.res_data, bus.res_v, bus.res_c, bus.res_valid, op_count, bus.in_ready}
            !== {8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset: a=%h b=%h sel=%b data=%h v=%b c=%b valid=%b cnt=%0d ready=%b required zeros ready=1",
                     alu_a, alu_b, alu_sel, bus.res_data, bus.res_v, bus.res_c, bus.res_valid, op_count, bus.in_ready);
        end
        rst = 1'b0;
        exp_cnt = 8'd0;
    endtask

    task automatic test_reset_mid;
        bus.res_ready = 1'b0;
        send_beat(8'h33, 2'b00);
        checks++;
        if (alu_a !== 8'h33 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL got_a: alu_a=%h in_ready=%b required 33 1", alu_a, bus.in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({alu_a, alu_b, alu_sel, bus.res_data, bus.res_v, bus.res_c, bus.res_valid, op_count, bus.in_ready}
            !== {8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_got_a: a=%h valid=%b cnt=%0d ready=%b required 00 0 0 1",
                     alu_a, bus.res_valid, op_count, bus.in_ready);
        end
        send_beat(8'hF0, 2'b00);
        send_beat(8'h20, 2'b00);
        @(posedge clk); #1;
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h10 || bus.res_c !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_result: valid=%b data=%h c=%b required 1 10 1",
                     bus.res_valid, bus.res_data, bus.res_c);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({alu_a, alu_b, alu_sel, bus.res_data, bus.res_v, bus.res_c, bus.res_valid, op_count, bus.in_ready}
            !== {8'h00, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_result: data=%h c=%b valid=%b cnt=%0d ready=%b required 00 0 0 0 1",
                     bus.res_data, bus.res_c, bus.res_valid, op_count, bus.in_ready);
        end
        exp_cnt = 8'd0;
    endtask

    task automatic test_add;
        do_txn(8'h0F, 8'h05, 2'b00, 0, {1'b0, 1'b0, 8'h14});
    endtask

    task automatic test_back_to_back;
        do_txn(8'h0F, 8'h05, 2'b01, 0, {1'b0, 1'b0, 8'h0A});
        do_txn(8'h0F, 8'h05, 2'b10, 0, {1'b0, 1'b0, 8'h10});
        do_txn(8'h0F, 8'h05, 2'b11, 0, {1'b0, 1'b0, 8'h0F});
        checks++;
        if (op_count !== 8'd4) begin
            errors++;
            $display("FAIL count4: op_count=%0d required 4", op_count);
        end
    endtask

    task automatic test_stall;
        do_txn(8'h3C, 8'h11, 2'b00, 5, {1'b0, 1'b0, 8'h4D});
    endtask

    task automatic test_overflow;
        do_txn(8'h7F, 8'h01, 2'b00, 0, {1'b1, 1'b0, 8'h80});
        do_txn(8'h80, 8'h01, 2'b01, 0, {1'b1, 1'b0, 8'h7F});
        do_txn(8'hFF, 8'h00, 2'b10, 0, {1'b0, 1'b1, 8'h00});
    endtask

    task automatic test_wrap;
        logic [7:0] a, b;
        logic [1:0] op;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = 2'($urandom);
            do_txn(a, b, op, 0, alu_fn(a, b, op));
        end
        checks++;
        if (op_count !== 8'd0) begin
            errors++;
            $display("FAIL wrap: op_count=%0d required 0", op_count);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_op     = 2'b00;
        bus.res_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_reset_mid();
        test_add();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
